// File: rtl/truth_table_pkg.sv
// truth_table_pkg: shared state encoding and widths for the truth-table sequencer
package truth_table_pkg;
  localparam int ROWS = 16;
  localparam int CODE_W = 4;
  localparam int RESULT_W = 10;
  localparam logic [CODE_W-1:0] LAST_ROW = CODE_W'(ROWS - 1);
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, EMIT, DONE} state_e;
endpackage

// File: rtl/settle_timer.sv
// settle_timer: loadable 4-bit down-counter flagging when the settle window has elapsed
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] cycles_i,
  output logic       expired_o
);
  logic [3:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? cycles_i : (cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q);
  always_ff @(posedge clk) cnt_q <= rst ? 4'd0 : cnt_d;
  assign expired_o = cnt_q == 4'd0;
endmodule

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps all 16 input codes, waits for the decoder to settle and streams each result row
module truth_table_sequencer
  import truth_table_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                w,
  output logic                x,
  output logic                y,
  output logic                z,
  input  logic [RESULT_W-1:0] r_in,
  output logic                row_valid,
  input  logic                row_ready,
  output logic [CODE_W-1:0]   row_index,
  output logic [RESULT_W-1:0] row_data,
  output logic                busy,
  output logic                done,
  output logic [RESULT_W-1:0] checksum
);
  // Timer runs SETTLE_CYCLES-1 down to zero, so SETTLE exits on the cycle it sees expiry
  localparam logic [3:0] SETTLE_LOAD = SETTLE_CYCLES == 0 ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  state_e state_q, state_d;
  logic [CODE_W-1:0] idx_q, idx_d, code_q, code_d, ridx_q, ridx_d;
  logic [RESULT_W-1:0] data_q, data_d, sum_q, sum_d;
  logic vld_q, vld_d, busy_q, done_q, load, expired;
  settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .cycles_i (SETTLE_LOAD),
    .expired_o(expired)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    code_d = code_q;
    ridx_d = ridx_q;
    data_d = data_q;
    sum_d = sum_q;
    vld_d = vld_q;
    load = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = DRIVE;
        idx_d = '0;
        code_d = '0;
        sum_d = '0;
      end
      DRIVE: begin
        load = 1'b1;
        state_d = SETTLE_CYCLES == 0 ? EMIT : SETTLE;
      end
      SETTLE: if (expired) state_d = EMIT;
      EMIT: if (row_ready) begin
        vld_d = 1'b0;
        sum_d = sum_q ^ data_q;
        state_d = idx_q == LAST_ROW ? DONE : DRIVE;
        idx_d = idx_q == LAST_ROW ? idx_q : idx_q + 1'b1;
        code_d = idx_d;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == EMIT && state_q != EMIT) begin
      vld_d = 1'b1;
      data_d = r_in;
      ridx_d = idx_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      code_q <= '0;
      ridx_q <= '0;
      data_q <= '0;
      sum_q <= '0;
      vld_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      code_q <= code_d;
      ridx_q <= ridx_d;
      data_q <= data_d;
      sum_q <= sum_d;
      vld_q <= vld_d;
      busy_q <= state_d inside {DRIVE, SETTLE, EMIT};
      done_q <= state_d == DONE;
    end
  end
  assign {w, x, y, z} = code_q;
  assign row_valid = vld_q;
  assign row_index = ridx_q;
  assign row_data = data_q;
  assign busy = busy_q;
  assign done = done_q;
  assign checksum = sum_q;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: directed table-driven checks of sweep timing, stalls, reset and restart
module tb_truth_table_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, row_ready = 1'b1;
  logic w, x, y, z, row_valid, busy, done;
  logic [3:0] row_index;
  logic [9:0] row_data, checksum, r_in;
  logic start0 = 1'b0, ready0 = 1'b1;
  logic w0, x0, y0, z0, v0, busy0, done0;
  logic [3:0] idx0;
  logic [9:0] d0, sum0;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [3:0] idx; logic [9:0] data; logic [9:0] sum;} row_t;
  row_t tbl[16];
  always #5 clk = ~clk;
  assign r_in = {6'b0, w, x, y, z};
  truth_table_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .w(w), .x(x), .y(y), .z(z), .r_in(r_in),
    .row_valid(row_valid), .row_ready(row_ready), .row_index(row_index), .row_data(row_data),
    .busy(busy), .done(done), .checksum(checksum)
  );
  truth_table_sequencer #(.SETTLE_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .w(w0), .x(x0), .y(y0), .z(z0), .r_in(10'h2A5),
    .row_valid(v0), .row_ready(ready0), .row_index(idx0), .row_data(d0),
    .busy(busy0), .done(done0), .checksum(sum0)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_zero;
    chk("rst_wxyz", {w, x, y, z}, 0);
    chk("rst_valid", row_valid, 0);
    chk("rst_index", row_index, 0);
    chk("rst_data", row_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", checksum, 0);
  endtask
  task automatic run_sweep(input int stall_row, input int start_row);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_done_low", done, 0);
    chk("start_sum_clr", checksum, 0);
    chk("start_busy", busy, 1);
    for (int i = 0; i < 16; i++) begin
      chk("drive_code", {w, x, y, z}, i);
      chk("drive_valid", row_valid, 0);
      tick;
      if (i == start_row) start = 1'b1;
      tick;
      start = 1'b0;
      chk("settle_valid", row_valid, 0);
      tick;
      chk("emit_valid", row_valid, 1);
      chk("emit_index", row_index, tbl[i].idx);
      chk("emit_data", row_data, tbl[i].data);
      chk("emit_code", {w, x, y, z}, i);
      if (i == stall_row) begin
        row_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick;
          chk("stall_valid", row_valid, 1);
          chk("stall_data", row_data, tbl[i].data);
          chk("stall_index", row_index, tbl[i].idx);
          chk("stall_code", {w, x, y, z}, i);
        end
        row_ready = 1'b1;
      end
      tick;
      chk("xfer_valid_low", row_valid, 0);
      chk("xfer_sum", checksum, tbl[i].sum);
    end
    chk("done_high", done, 1);
    chk("done_busy", busy, 0);
    chk("done_code", {w, x, y, z}, 15);
    chk("done_sum", checksum, 0);
    tick;
    chk("done_hold", done, 1);
    chk("done_hold_code", {w, x, y, z}, 15);
  endtask
  initial begin
    logic [9:0] acc = '0;
    int n;
    for (int i = 0; i < 16; i++) begin
      acc ^= 10'(i);
      tbl[i] = '{idx: 4'(i), data: 10'(i), sum: acc};
    end
    tick;
    tick;
    rst = 1'b0;
    tick;
    chk_zero;
    run_sweep(-1, -1);
    run_sweep(7, 3);
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    while (!(row_valid && row_index == 4'd5) && n < 200) begin
      tick;
      n++;
    end
    chk("reach_row5", n < 200, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk_zero;
    tick;
    chk("idle_after_rst", busy, 0);
    run_sweep(-1, -1);
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick;
      chk("s0_valid", v0, 1);
      chk("s0_data", d0, 10'h2A5);
      chk("s0_index", idx0, i);
      tick;
      chk("s0_valid_low", v0, 0);
      chk("s0_sum", sum0, (i % 2 == 0) ? 10'h2A5 : 10'h000);
    end
    chk("s0_done", done0, 1);
    chk("s0_final_sum", sum0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, number of clock cycles the input code is held before the 10-bit result is sampled; legal range 0..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request one full 16-row sweep; sampled only in IDLE or DONE.
REQ-005 w, x, y, z  output  1 each  registered input code to the decoder stage; w is MSB (weight 8), z is LSB (weight 1).
REQ-006 r_in  input  10  decoder result bits r9..r0, bit i = ri.
REQ-007 row_valid  output  1  captured row available.
REQ-008 row_ready  input  1  consumer accepts the row.
REQ-009 row_index  output  4  code {w,x,y,z} of the captured row.
REQ-010 row_data  output  10  r_in sampled for that code.
REQ-011 busy  output  1  high in DRIVE, SETTLE and EMIT.
REQ-012 done  output  1  high in DONE.
REQ-013 checksum  output  10  running XOR of all accepted row_data in the current sweep.

Function
REQ-014 The FSM SHALL have exactly five states: IDLE, DRIVE, SETTLE, EMIT, DONE.
REQ-015 IDLE/DONE with start=1 SHALL go to DRIVE with index 0, clear checksum, and drop done on the next edge.
REQ-016 DRIVE SHALL last exactly one cycle with {w,x,y,z} = index, then go to SETTLE, or to EMIT when SETTLE_CYCLES=0.
REQ-017 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to EMIT.
REQ-018 Entry into EMIT SHALL capture r_in into row_data and index into row_index, with row_valid high from the first EMIT cycle.
REQ-019 row_valid, row_data, row_index, w, x, y and z SHALL stay stable while row_valid=1 and row_ready=0.
REQ-020 A row transfer SHALL occur on an edge where row_valid=1 and row_ready=1; row_valid SHALL then be low the next cycle, and checksum SHALL be updated with that row_data on the same edge.
REQ-021 After a transfer with index<15, the FSM SHALL increment index and go to DRIVE.
REQ-022 After a transfer with index=15, the FSM SHALL go to DONE; index SHALL NOT wrap.
REQ-023 With row_ready held high, start at cycle T SHALL give the first row_valid at T+2+SETTLE_CYCLES and a row period of SETTLE_CYCLES+2 cycles.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 {w,x,y,z} SHALL hold its last driven code in DONE and until the next DRIVE.
REQ-026 In DONE, checksum SHALL hold the XOR of all 16 rows until the next start.
REQ-027 Outputs SHALL be registered, with no combinational path from r_in or row_ready to any output.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE in any state, including mid-sweep.
REQ-029 At that same edge, rst SHALL set w, x, y, z, row_valid, row_index, row_data, busy, done, checksum and the settle count to 0.
REQ-030 rst SHALL take priority over start and over any row transfer on the same edge; a row pending at reset SHALL be discarded.

Structure
REQ-031 Package truth_table_pkg SHALL hold the state enum, ROWS=16, CODE_W=4 and RESULT_W=10.
REQ-032 The settle delay SHALL be a sub-module settle_timer: load, count-down, expired flag, 4-bit counter.
REQ-033 The top level SHALL contain the FSM, index register, capture registers and checksum.

Verification
REQ-034 Loopback r_in={6'b0,w,x,y,z}, SETTLE_CYCLES=2, row_ready=1, start pulse at T -> first row_valid at T+4; 16 rows with row_data=row_index=0..15; done at T+4+16*4-... (DONE one cycle after last transfer); checksum=10'h000.
REQ-035 Same setup with row_ready low for 3 cycles during row 7 -> row_valid, row_data=7 and wxyz=0111 held 3 cycles; transfer on the 4th cycle; row 8 follows normally.
REQ-036 SETTLE_CYCLES=0 with constant r_in=10'h2A5 -> row period 2 cycles; every row_data=10'h2A5; final checksum=10'h000.
REQ-037 rst asserted during EMIT of row 5 -> next cycle all outputs 0, state IDLE; a fresh start restarts at index 0.
REQ-038 start pulsed during SETTLE of row 3 -> ignored; sweep continues to 15 unchanged.
REQ-039 start in DONE -> done low next cycle, checksum=0, wxyz=0000, new sweep completes identically.
